st_channel_filter_adapter: RTL and testbench

//  Avalon-ST channel adapter for the bytes-to-packets path behind the host master.

---
 rtl/st_adapter_pkg.sv | 18 +
 rtl/st_skid_buffer.sv | 56 +++++
 rtl/st_channel_filter_adapter.sv | 114 +++++++++++
 tb/tb_st_channel_filter_adapter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_adapter_pkg.sv
// Shared definitions for the Avalon-ST channel filter adapter: FSM encoding
// and the packing of a forwarded beat {data, channel, sop, eop}.
package st_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Flags sit in the two LSBs of a packed beat: sop at bit 1, eop at bit 0.
  localparam int FLAG_W = 2;

  function automatic int payload_w(input int data_w, input int ch_w);
    return data_w + ch_w + FLAG_W;
  endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry ready/valid register slice. push_ready is registered and drops
// only once both entries are occupied, so one downstream stall costs no beat.
module st_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign push      = push_valid & push_ready;
  assign pop       = pop_valid & pop_ready;
  assign pop_valid = (count_q != 2'd0);
  assign pop_data  = head_q;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      push_ready <= 1'b0;
    end else begin
      count_q    <= count_d;
      push_ready <= (count_d != 2'd2);
      // Head takes new data when the slot it would occupy is the output slot.
      if (push && (count_q == 2'd0 || (pop && count_q == 2'd1)))
        head_q <= push_data;
      else if (pop && count_q == 2'd2)
        head_q <= tail_q;
      if (push && !pop && count_q == 2'd1)
        tail_q <= push_data;
    end
  end

endmodule

// File: rtl/st_channel_filter_adapter.sv
// Avalon-ST channel filter: forwards packets whose SOP channel lies in
// [CHANNEL_OFFSET, MAX_CHANNEL], remaps the channel, and counts discards.
module st_channel_filter_adapter
  import st_adapter_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int IN_CHANNEL_W   = 8,
  parameter int OUT_CHANNEL_W  = 4,
  parameter int MAX_CHANNEL    = 0,
  parameter int CHANNEL_OFFSET = 0,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [DROP_CNT_W-1:0]    drop_count,
  output logic [DROP_CNT_W-1:0]    orphan_count,
  output logic [1:0]               fsm_state
);

  localparam int PAY_W = payload_w(DATA_W, OUT_CHANNEL_W);
  localparam logic [IN_CHANNEL_W-1:0] OFF_CH = IN_CHANNEL_W'(CHANNEL_OFFSET);

  // Handshake: a beat moves on in_valid&in_ready (input) and out_valid&out_ready
  // (output); in_ready depends only on buffer occupancy, never on in_valid.
  state_t                   state_q, state_d;
  logic [OUT_CHANNEL_W-1:0] chan_q, chan_d, chan_out, remap;
  logic                     accept, in_range, fwd, drop_inc, orphan_inc;
  logic [PAY_W-1:0]         push_data, pop_data;

  assign accept    = in_valid & in_ready;
  assign in_range  = (int'(in_channel) <= MAX_CHANNEL) && (int'(in_channel) >= CHANNEL_OFFSET);
  assign remap     = OUT_CHANNEL_W'(in_channel - OFF_CH);
  assign fsm_state = state_q;

  // An SOP always restarts evaluation, whatever state the previous packet left.
  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    chan_out   = chan_q;
    fwd        = 1'b0;
    drop_inc   = 1'b0;
    orphan_inc = 1'b0;
    if (accept) begin
      if (in_startofpacket) begin
        if (in_range) begin
          fwd      = 1'b1;
          chan_d   = remap;
          chan_out = remap;
          state_d  = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          drop_inc = 1'b1;
          state_d  = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_PASS: begin
            fwd = 1'b1;
            if (in_endofpacket) state_d = ST_IDLE;
          end
          ST_DROP: begin
            if (in_endofpacket) state_d = ST_IDLE;
          end
          default: orphan_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      drop_count   <= '0;
      orphan_count <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      if (drop_inc && drop_count != '1)
        drop_count <= drop_count + 1'b1;
      if (orphan_inc && orphan_count != '1)
        orphan_count <= orphan_count + 1'b1;
    end
  end

  assign push_data = {in_data, chan_out, in_startofpacket, in_endofpacket};

  st_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_valid (fwd),
    .push_data  (push_data),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (pop_data)
  );

  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = pop_data;

endmodule

// File: tb/tb_st_channel_filter_adapter.sv
// Bench for st_channel_filter_adapter: packet-level reference model feeding
// an expected-beat queue, plus an occupancy tracker for the ready/valid flags.
module tb_st_channel_filter_adapter;

  localparam int DATA_W = 8;
  localparam int IN_CW  = 8;
  localparam int OUT_CW = 4;
  localparam int MAX_CH = 3;
  localparam int OFF    = 0;
  localparam int DCW    = 4;
  localparam int W      = DATA_W + OUT_CW + 2;
  localparam int SAT    = (1 << DCW) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_ready;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [IN_CW-1:0]  in_channel = '0;
  logic              in_startofpacket = 1'b0;
  logic              in_endofpacket = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [OUT_CW-1:0] out_channel;
  logic              out_startofpacket;
  logic              out_endofpacket;
  logic [DCW-1:0]    drop_count;
  logic [DCW-1:0]    orphan_count;
  logic [1:0]        fsm_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int occ = 0;
  bit armed = 0;
  bit push_pending = 0;
  bit pop_pending = 0;
  int rdy_mode = 0;
  int rdy_idx = 0;
  int m_state = 0;
  logic [OUT_CW-1:0] m_ch = '0;
  int exp_drop = 0;
  int exp_orphan = 0;

  always #5 clk = ~clk;

  st_channel_filter_adapter #(
    .DATA_W         (DATA_W),
    .IN_CHANNEL_W   (IN_CW),
    .OUT_CHANNEL_W  (OUT_CW),
    .MAX_CHANNEL    (MAX_CH),
    .CHANNEL_OFFSET (OFF),
    .DROP_CNT_W     (DCW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .drop_count        (drop_count),
    .orphan_count      (orphan_count),
    .fsm_state         (fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Occupancy tracker: pushes come from the model, pops from the output handshake.
  always @(posedge clk) begin
    if (reset_n) begin
      occ = occ + int'(push_pending) - int'(pop_pending);
      armed = 1;
    end
    push_pending = 0;
    pop_pending = 0;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
        rdy_idx++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready", 32'(in_ready), 32'(armed && occ != 2));
      chk("out_valid", 32'(out_valid), 32'(occ != 0));
      if (out_valid && out_ready) begin
        pop_pending = 1;
        if (exp_q.size() == 0)
          chk("unexpected_beat", 32'(1), 32'(0));
        else
          chk("beat", 32'({out_data, out_channel, out_startofpacket, out_endofpacket}),
              32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_accept(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
    if (sop) begin
      if (int'(ch) <= MAX_CH && int'(ch) >= OFF) begin
        m_ch = OUT_CW'(ch - 8'(OFF));
        exp_q.push_back({d, m_ch, sop, eop});
        push_pending = 1;
        m_state = eop ? 0 : 1;
      end else begin
        if (exp_drop < SAT) exp_drop++;
        m_state = eop ? 0 : 2;
      end
    end else if (m_state == 1) begin
      exp_q.push_back({d, m_ch, sop, eop});
      push_pending = 1;
      if (eop) m_state = 0;
    end else if (m_state == 2) begin
      if (eop) m_state = 0;
    end else if (exp_orphan < SAT) begin
      exp_orphan++;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
    bit done = 0;
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_channel = ch;
    in_startofpacket = sop;
    in_endofpacket = eop;
    while (!done && n < 100) begin
      @(negedge clk);
      if (reset_n && in_ready) begin
        done = 1;
        model_accept(d, ch, sop, eop);
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] ch, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++)
      send_beat(base + 8'(i), (i == 0) ? ch : 8'($urandom_range(0, 255)), i == 0, i == n - 1);
    go_idle();
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    while ((exp_q.size() != 0 || occ != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_state = 0;
    exp_drop = 0;
    exp_orphan = 0;
    occ = 0;
    armed = 0;
    push_pending = 0;
    pop_pending = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_drop", 32'(drop_count), 32'(0));
    chk("rst_orphan", 32'(orphan_count), 32'(0));
    chk("rst_state", 32'(fsm_state), 32'(0));
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1;
    chk("ready_after_edge", 32'(in_ready), 32'(1));

    // 2: 4-beat forwarded packet, channel held despite mid-packet changes
    for (int i = 0; i < 4; i++)
      send_beat(8'h11 * 8'(i + 1), (i == 0) ? 8'd2 : 8'($urandom_range(4, 255)), i == 0, i == 3);
    go_idle();
    drain();

    // 3: dropped packet then single-beat packet on channel 0
    send_pkt(8'd5, 3, 8'h60);
    send_pkt(8'd0, 1, 8'h70);
    drain();
    chk("drop_after_t3", 32'(drop_count), 32'(1));
    chk("drop_model_t3", 32'(drop_count), 32'(exp_drop));

    // 4: back-to-back stream against a 1,0,0,1 ready pattern
    rdy_idx = 0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    send_pkt(8'd1, 10, 8'h80);
    drain();

    // 5: orphan beat in IDLE, then SOP arriving mid-packet
    send_beat(8'hAA, 8'd1, 1'b0, 1'b0);
    go_idle();
    drain();
    chk("orphan_t5", 32'(orphan_count), 32'(1));
    send_beat(8'hB0, 8'd1, 1'b1, 1'b0);
    send_beat(8'hB1, 8'd9, 1'b0, 1'b0);
    send_beat(8'hC0, 8'd3, 1'b1, 1'b0);
    send_beat(8'hC1, 8'd0, 1'b0, 1'b1);
    go_idle();
    drain();
    chk("state_t5", 32'(fsm_state), 32'(0));

    // 6: reset mid-packet, orphans after release, drop counter saturation
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send_beat(8'h51, 8'd1, 1'b1, 1'b0);
    send_beat(8'h52, 8'd1, 1'b0, 1'b0);
    go_idle();
    reset_n = 1'b0;
    clear_model();
    #1;
    chk("rst6_out_valid", 32'(out_valid), 32'(0));
    chk("rst6_out_data", 32'(out_data), 32'(0));
    chk("rst6_out_sop", 32'(out_startofpacket), 32'(0));
    chk("rst6_in_ready", 32'(in_ready), 32'(0));
    chk("rst6_orphan", 32'(orphan_count), 32'(0));
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_beat(8'h53, 8'd1, 1'b0, 1'b0);
    send_beat(8'h54, 8'd1, 1'b0, 1'b1);
    go_idle();
    drain();
    chk("orphan_t6", 32'(orphan_count), 32'(2));
    for (int i = 0; i < SAT + 1; i++)
      send_beat(8'(i), 8'd9, 1'b1, 1'b1);
    go_idle();
    drain();
    chk("drop_saturated", 32'(drop_count), 32'(SAT));

    // Random mixed traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 60; i++)
      send_beat(8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)),
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
    go_idle();
    drain();
    chk("drop_random", 32'(drop_count), 32'(exp_drop));
    chk("orphan_random", 32'(orphan_count), 32'(exp_orphan));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
